mem_arbiter: RTL
================

# mem_arbiter

Two-master, one-slave memory arbiter that lets the instruction fetch unit (IFU) and the load/store unit (LSU) share a single memory port in the multi-cycle core. It sits between the IFU/LSU and the memory interface. It accepts one request at a time, holds the grant until the memory response returns, and routes the response back to the owning master. The LSU has priority, and a starvation limit guarantees forward progress for instruction fetch.

## Interface
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width; the write mask is `DATA_W/8` bits.
- `STARVE_LIM`, 4, number of consecutive contested LSU grants after which the IFU wins; must be 1..15.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `ifu_req_valid` in 1, `ifu_req_ready` out 1, `ifu_addr` in `ADDR_W`: IFU read request.
- `ifu_resp_valid` out 1, `ifu_rdata` out `DATA_W`: IFU response.
- `lsu_req_valid` in 1, `lsu_req_ready` out 1, `lsu_addr` in `ADDR_W`: LSU request.
- `lsu_wen` in 1, `lsu_wdata` in `DATA_W`, `lsu_wmask` in `DATA_W/8`: LSU write controls.
- `lsu_resp_valid` out 1, `lsu_rdata` out `DATA_W`: LSU response; also issued for writes as the write acknowledge.
- `mem_req_valid` out 1, `mem_req_ready` in 1: memory request handshake.
- `mem_addr` out `ADDR_W`, `mem_wen` out 1, `mem_wdata` out `DATA_W`, `mem_wmask` out `DATA_W/8`: memory request payload.
- `mem_resp_valid` in 1, `mem_rdata` in `DATA_W`: memory response.

## Operation
- **Handshake.** A request transfers on a cycle where valid && ready.
  - Masters hold valid and payload stable until the transfer.
  - Masters always accept responses; there is no response backpressure.
- **States.**
  - IDLE: no selection locked.
  - HOLD: a selection is presented to memory but not yet accepted.
  - WAIT: a request is outstanding and the owner is recorded.
- **Selection in IDLE** (combinational). Candidates are the masters with valid high.
  - LSU wins unless both are valid and `streak == STARVE_LIM`; in that case IFU wins.
  - `mem_req_valid` = the winner's valid.
  - The winner's payload is muxed onto `mem_*`. The IFU drives `mem_wen=0`, `mem_wdata=0` and `mem_wmask=0`.
  - Winner's ready = `mem_req_ready`; the loser's ready = 0.
- **IDLE transitions.**
  - Transfer: go to WAIT with the owner set to the winner.
  - Winner valid but `mem_req_ready=0`: register the selection and go to HOLD.
- **HOLD.**
  - Presents only the locked master. It does not switch even if a higher-priority master raises valid.
  - On transfer, go to WAIT.
- **WAIT.**
  - `mem_req_valid=0`; both readys are 0.
  - On `mem_resp_valid`, pulse the owner's `*_resp_valid` for exactly that cycle, with `*_rdata=mem_rdata`, then go to IDLE.
  - The non-owner's `*_resp_valid` stays 0.
- **Streak counter** (`$clog2(STARVE_LIM+1)` bits, updated at the grant transfer).
  - LSU grant while `ifu_req_valid=1`: increment, saturating at `STARVE_LIM`.
  - LSU grant while `ifu_req_valid=0`: clear.
  - IFU grant: clear.
- **Stray response.** `mem_resp_valid` in IDLE or HOLD is dropped: no master response and no state change.
- **Response rdata.** `*_rdata` is don't-care when `*_resp_valid=0`; the implementation drives `mem_rdata` to both.

## Timing
- **Reset values.**
  - State: IDLE; streak: 0; owner: IFU.
  - All `*_resp_valid`, `*_req_ready` and `mem_req_valid`: 0 in the reset cycle.
  - Payload outputs: 0.
- **Reset mid-operation.** `rst` in any state returns to IDLE and discards the lock and owner. A late response for the aborted request is dropped as stray.
- **Latency.**
  - Request path: zero cycles. IDLE valid reaches `mem_req_valid` in the same cycle.
  - Response path: zero cycles. `mem_resp_valid` reaches `*_resp_valid` in the same cycle.
  - Back-to-back: the earliest next transfer is the cycle after the response cycle, so a 1-cycle memory gives one transaction per 2 cycles.
- **Simultaneous events.**
  - A response in WAIT and a new master request in the same cycle: the response is delivered, and the request waits for IDLE on the next cycle.
  - Both masters valid in the same cycle: priority as above.

## Test plan
- **IFU only.** `ifu_addr=0x80000000`, memory ready; response `0x00000413` after 3 cycles. Expect:
  - Transfer in cycle 0.
  - `ifu_resp_valid` pulses once in cycle 3 with `ifu_rdata=0x00000413`.
  - `lsu_resp_valid` stays 0.
- **Contention.** Both valid in the same cycle; LSU store with `addr=0x80001000`, `wdata=0xDEADBEEF`, `wmask=0xF`. Expect:
  - The LSU is granted first and `mem_wen=1`.
  - The IFU is granted in the first IDLE cycle after the LSU acknowledge.
- **Starvation.** IFU held valid; LSU issues 6 back-to-back requests; `STARVE_LIM=4`. Expect:
  - The grant order is L, L, L, L, I, L, L.
  - Streak reads 0 after the IFU grant.
- **HOLD lock.** IFU valid alone with `mem_req_ready=0` for 3 cycles; the LSU raises valid in cycle 1. Expect:
  - `mem_addr` stays at the IFU address.
  - `lsu_req_ready` stays 0 until the IFU transfer.
- **Stray and reset.** Assert `rst` for 1 cycle while in WAIT, then pulse `mem_resp_valid` 2 cycles later. Expect:
  - Neither `*_resp_valid` pulses.
  - The next IFU request is granted normally.
- **Zero-latency memory.** Response on the cycle after each transfer for 10 IFU requests. Expect:
  - Exactly 10 `ifu_resp_valid` pulses over 20 cycles.
  - The responses arrive in request order.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the instruction fetch unit
// (IFU) and the load/store unit (LSU). One request is in flight at a time;
// the grant is held until memory responds, and the response is steered back
// to the master that issued it. The LSU has priority, but after STARVE_LIM
// consecutive LSU grants taken while the IFU was also waiting, the IFU wins
// the next contested arbitration.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_LIM = 4   // legal range 1..15
) (
  input  logic                clk,
  input  logic                rst,
  // IFU read request / response
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_resp_valid,
  output logic [DATA_W-1:0]   ifu_rdata,
  // LSU request / response (response doubles as the write acknowledge)
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_resp_valid,
  output logic [DATA_W-1:0]   lsu_rdata,
  // Memory port
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int                STRK_W   = $clog2(STARVE_LIM + 1);
  localparam logic [STRK_W-1:0] STRK_MAX = STRK_W'(STARVE_LIM);

  // IDLE: nothing locked; HOLD: selection presented but not yet accepted;
  // WAIT: one request outstanding, owner recorded.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  logic [1:0]        state_q,  state_d;
  logic              sel_q,    sel_d;     // locked master in HOLD (1 = LSU)
  logic              owner_q,  owner_d;   // owner of outstanding request (1 = LSU)
  logic [STRK_W-1:0] streak_q, streak_d;  // consecutive contested LSU grants

  logic              sel_lsu;      // master currently presented (1 = LSU)
  logic              cand_valid;   // presented master has valid high
  logic              present;      // request actually driven to memory
  logic              xfer;         // memory accepts the request this cycle
  logic              deliver;      // memory response routed to owner
  logic [STRK_W-1:0] streak_bump;  // saturating increment of the streak
  logic [STRK_W-1:0] grant_streak; // streak value to load on a grant

  // Choose which master is presented to memory this cycle.
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path through the case leaves it holding an old value
    // (which would infer a latch).
    sel_lsu    = 1'b0;
    cand_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // LSU wins unless the IFU is also waiting and has been passed over
        // STARVE_LIM times in a row.
        sel_lsu    = lsu_req_valid && !(ifu_req_valid && (streak_q == STRK_MAX));
        cand_valid = lsu_req_valid || ifu_req_valid;
      end
      ST_HOLD: begin
        // The lock is never re-arbitrated, even if the LSU shows up.
        sel_lsu    = sel_q;
        cand_valid = sel_q ? lsu_req_valid : ifu_req_valid;
      end
      default: begin
      end
    endcase
  end

  assign present      = cand_valid && !rst;
  assign xfer         = present && mem_req_ready;
  assign deliver      = !rst && (state_q == ST_WAIT) && mem_resp_valid;
  assign streak_bump  = (streak_q == STRK_MAX) ? streak_q : streak_q + 1'b1;
  assign grant_streak = (sel_lsu && ifu_req_valid) ? streak_bump : '0;

  // Drive the memory request payload and both request/response channels.
  always_comb begin
    mem_req_valid  = present;
    ifu_req_ready  = present && !sel_lsu && mem_req_ready;
    lsu_req_ready  = present &&  sel_lsu && mem_req_ready;
    mem_addr       = '0;
    mem_wen        = 1'b0;
    mem_wdata      = '0;
    mem_wmask      = '0;
    if (present) begin
      if (sel_lsu) begin
        mem_addr  = lsu_addr;
        mem_wen   = lsu_wen;
        mem_wdata = lsu_wdata;
        mem_wmask = lsu_wmask;
      end else begin
        mem_addr  = ifu_addr;
      end
    end
    ifu_resp_valid = deliver && !owner_q;
    lsu_resp_valid = deliver &&  owner_q;
    // rdata only matters alongside resp_valid, so both see memory directly.
    ifu_rdata      = mem_rdata;
    lsu_rdata      = mem_rdata;
  end

  // Next-state logic: lock, grant, and release on the memory response.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    owner_d  = owner_q;
    streak_d = streak_q;
    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          state_d  = ST_WAIT;
          owner_d  = sel_lsu;
          streak_d = grant_streak;
        end else if (present) begin
          state_d  = ST_HOLD;
          sel_d    = sel_lsu;
        end
      end
      ST_HOLD: begin
        if (xfer) begin
          state_d  = ST_WAIT;
          owner_d  = sel_q;
          streak_d = grant_streak;
        end
      end
      ST_WAIT: begin
        if (mem_resp_valid) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before this clock edge.
    if (rst) begin
      state_q  <= ST_IDLE;
      sel_q    <= 1'b0;
      owner_q  <= 1'b0;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      owner_q  <= owner_d;
      streak_q <= streak_d;
    end
  end

endmodule
